// File: rtl/fp32_rf_wb_arbiter_if.sv
// Bundles the writeback handshakes and the register-file write port.
// The arbiter connects through the slave modport and its driver through the master modport.
interface fp32_rf_wb_arbiter_if;
  logic        a_valid;
  logic        a_ready;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  logic        wen;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic        idle;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_ready, b_ready, wen, wa, wd, idle
  );

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_ready, b_ready, wen, wa, wd, idle
  );
endinterface

// File: rtl/fp32_rf_wb_arbiter.sv
// Write-port arbiter for the 32x32 FP register file.
// Source A (FPU results) and source B (FP loads) each fill a private FIFO.
// One FIFO head per cycle is popped onto the single write port (wen/wa/wd).
// Writes to register 0 are popped and discarded without raising wen.
// Build option FP_WB_RR_EN: when defined, A and B alternate under a 1-bit
// round-robin pointer; when undefined, A has fixed priority over B.
//
// Handshake: a beat transfers at a rising edge when x_valid && x_ready.
// x_ready is decoded only from the registered FIFO count (never from x_valid),
// and a full FIFO stays not-ready even if it pops in the same cycle.
module fp32_rf_wb_arbiter #(
  parameter int DEPTH = 2
) (
  input logic                 clock,
  input logic                 reset,
  fp32_rf_wb_arbiter_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  // Entry layout: {addr[4:0], data[31:0]}
  logic [36:0]   mem_a [DEPTH];
  logic [36:0]   mem_b [DEPTH];
  logic [AW-1:0] wr_ptr_a, rd_ptr_a, wr_ptr_b, rd_ptr_b;
  logic [AW:0]   count_a, count_b;

  logic empty_a, empty_b, full_a, full_b;
  logic push_a, push_b, grant_a, grant_b;
  logic [36:0] head_a, head_b;

`ifdef FP_WB_RR_EN
  // Set when B holds priority for the next contended cycle.
  logic favour_b;
`endif

  assign empty_a = (count_a == '0);
  assign empty_b = (count_b == '0);
  assign full_a  = (count_a == FULL_CNT);
  assign full_b  = (count_b == FULL_CNT);

  assign push_a = bus.a_valid && !full_a;
  assign push_b = bus.b_valid && !full_b;

  assign head_a = mem_a[rd_ptr_a];
  assign head_b = mem_b[rd_ptr_b];

  assign bus.a_ready = !full_a;
  assign bus.b_ready = !full_b;
  assign bus.idle    = empty_a && empty_b && !bus.wen;

  // Pick at most one non-empty FIFO to pop this cycle.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
`ifdef FP_WB_RR_EN
    grant_a = !empty_a && (empty_b || !favour_b);
    grant_b = !empty_b && !grant_a;
`else
    grant_a = !empty_a;
    grant_b = !empty_b && empty_a;
`endif
  end

  // FIFO storage; contents need no reset because the counts gate every read.
  always_ff @(posedge clock) begin
    if (push_a) mem_a[wr_ptr_a] <= {bus.a_addr, bus.a_data};
    if (push_b) mem_b[wr_ptr_b] <= {bus.b_addr, bus.b_data};
  end

  // Pointers and occupancy counts for both FIFOs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_a <= '0;
      rd_ptr_a <= '0;
      count_a  <= '0;
      wr_ptr_b <= '0;
      rd_ptr_b <= '0;
      count_b  <= '0;
    end else begin
      if (push_a)  wr_ptr_a <= wr_ptr_a + AW'(1);
      if (grant_a) rd_ptr_a <= rd_ptr_a + AW'(1);
      count_a <= count_a + (AW+1)'(push_a) - (AW+1)'(grant_a);
      if (push_b)  wr_ptr_b <= wr_ptr_b + AW'(1);
      if (grant_b) rd_ptr_b <= rd_ptr_b + AW'(1);
      count_b <= count_b + (AW+1)'(push_b) - (AW+1)'(grant_b);
    end
  end

`ifdef FP_WB_RR_EN
  // Round-robin pointer moves away from whichever source was just granted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      favour_b <= 1'b0;
    end else if (grant_a) begin
      favour_b <= 1'b1;
    end else if (grant_b) begin
      favour_b <= 1'b0;
    end
  end
`endif

  // Registered write port; address 0 is consumed silently, idle cycles hold wa/wd.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.wen <= 1'b0;
      bus.wa  <= '0;
      bus.wd  <= '0;
    end else if (grant_a) begin
      bus.wen <= (head_a[36:32] != 5'd0);
      bus.wa  <= head_a[36:32];
      bus.wd  <= head_a[31:0];
    end else if (grant_b) begin
      bus.wen <= (head_b[36:32] != 5'd0);
      bus.wa  <= head_b[36:32];
      bus.wd  <= head_b[31:0];
    end else begin
      bus.wen <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fp32_rf_wb_arbiter.sv
// Directed bench for fp32_rf_wb_arbiter (DEPTH = 2).
// Expected write order depends on FP_WB_RR_EN, matching the DUT build.
module tb_fp32_rf_wb_arbiter;

  logic clock;
  logic reset;
  fp32_rf_wb_arbiter_if bus();

  fp32_rf_wb_arbiter #(.DEPTH(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  logic [36:0] exp_q[$];
  logic [36:0] mon_e;

  // Clock: 10 time-unit period, rising edges at 5, 15, ...
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [36:0] obs, input logic [36:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every register-file write must match the head of exp_q.
  always @(negedge clock) begin
    if (reset === 1'b1 && bus.wen === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_write_wen", 37'(bus.wen), 37'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("write_addr_data", {bus.wa, bus.wd}, mon_e);
      end
    end
  end

  task automatic idle_inputs();
    bus.a_valid = 1'b0;
    bus.a_addr  = '0;
    bus.a_data  = '0;
    bus.b_valid = 1'b0;
    bus.b_addr  = '0;
    bus.b_data  = '0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clock);
    while (bus.idle !== 1'b1 && n < 40) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_idle"}, 37'(bus.idle), 37'd1);
    check({tag, "_drained"}, 37'(exp_q.size()), 37'd0);
  endtask

  initial begin
    int a_sent;
    int b_sent;
    logic acc_a, acc_b, a_dropped, b_blocked;

    idle_inputs();
    reset = 1'b1;
    #1 reset = 1'b0;

    // ---- reset state ----
    @(negedge clock);
    check("rst_wen",     37'(bus.wen),     37'd0);
    check("rst_wa",      37'(bus.wa),      37'd0);
    check("rst_wd",      37'(bus.wd),      37'd0);
    check("rst_a_ready", 37'(bus.a_ready), 37'd1);
    check("rst_b_ready", 37'(bus.b_ready), 37'd1);
    check("rst_idle",    37'(bus.idle),    37'd1);
    @(negedge clock);
    reset = 1'b1;

    // ---- single write: push at edge k, write visible after edge k+1 ----
    @(negedge clock);
    bus.a_valid = 1'b1; bus.a_addr = 5'd5; bus.a_data = 32'h3F80_0000;
    exp_q.push_back({5'd5, 32'h3F80_0000});
    @(negedge clock);
    idle_inputs();
    check("single_not_yet_wen", 37'(bus.wen),  37'd0);
    check("single_not_idle",    37'(bus.idle), 37'd0);
    @(negedge clock);
    check("single_wen", 37'(bus.wen), 37'd1);
    check("single_wa",  37'(bus.wa),  37'd5);
    check("single_wd",  37'(bus.wd),  37'h3F80_0000);
    @(negedge clock);
    check("single_wen_one_cycle", 37'(bus.wen),  37'd0);
    check("single_idle_after",    37'(bus.idle), 37'd1);

    // ---- contention: A gets r1,r2 and B gets r3,r4 in the same cycles ----
    do_reset();
`ifdef FP_WB_RR_EN
    exp_q.push_back({5'd1, 32'h1111_1111});
    exp_q.push_back({5'd3, 32'h3333_3333});
    exp_q.push_back({5'd2, 32'h2222_2222});
    exp_q.push_back({5'd4, 32'h4444_4444});
`else
    exp_q.push_back({5'd1, 32'h1111_1111});
    exp_q.push_back({5'd2, 32'h2222_2222});
    exp_q.push_back({5'd3, 32'h3333_3333});
    exp_q.push_back({5'd4, 32'h4444_4444});
`endif
    @(negedge clock);
    bus.a_valid = 1'b1; bus.a_addr = 5'd1; bus.a_data = 32'h1111_1111;
    bus.b_valid = 1'b1; bus.b_addr = 5'd3; bus.b_data = 32'h3333_3333;
    @(negedge clock);
    bus.a_addr = 5'd2; bus.a_data = 32'h2222_2222;
    bus.b_addr = 5'd4; bus.b_data = 32'h4444_4444;
    @(negedge clock);
    idle_inputs();
    wait_idle("contention");

    // ---- backpressure: A holds valid for 4 entries while B backlogs 2 ----
    do_reset();
`ifdef FP_WB_RR_EN
    exp_q.push_back({5'd8,  32'hA000_0001});
    exp_q.push_back({5'd12, 32'hB000_0001});
    exp_q.push_back({5'd9,  32'hA000_0002});
    exp_q.push_back({5'd13, 32'hB000_0002});
    exp_q.push_back({5'd10, 32'hA000_0003});
    exp_q.push_back({5'd11, 32'hA000_0004});
`else
    exp_q.push_back({5'd8,  32'hA000_0001});
    exp_q.push_back({5'd9,  32'hA000_0002});
    exp_q.push_back({5'd10, 32'hA000_0003});
    exp_q.push_back({5'd11, 32'hA000_0004});
    exp_q.push_back({5'd12, 32'hB000_0001});
    exp_q.push_back({5'd13, 32'hB000_0002});
`endif
    a_sent = 0; b_sent = 0; a_dropped = 1'b0;
    @(negedge clock);
    for (int cyc = 0; cyc < 20 && (a_sent < 4 || b_sent < 2); cyc++) begin
      bus.a_valid = (a_sent < 4);
      bus.a_addr  = 5'(8 + a_sent);
      bus.a_data  = 32'hA000_0001 + 32'(a_sent);
      bus.b_valid = (b_sent < 2);
      bus.b_addr  = 5'(12 + b_sent);
      bus.b_data  = 32'hB000_0001 + 32'(b_sent);
      if (bus.a_valid && !bus.a_ready) a_dropped = 1'b1;
      acc_a = bus.a_valid && bus.a_ready;
      acc_b = bus.b_valid && bus.b_ready;
      @(negedge clock);
      if (cyc == 1) check("bp_b_full_after_two", 37'(bus.b_ready), 37'd0);
      if (acc_a) a_sent++;
      if (acc_b) b_sent++;
    end
    idle_inputs();
    check("bp_a_accepted", 37'(a_sent), 37'd4);
    check("bp_b_accepted", 37'(b_sent), 37'd2);
`ifdef FP_WB_RR_EN
    check("bp_a_ready_dropped", 37'(a_dropped), 37'd1);
`else
    check("bp_a_ready_dropped", 37'(a_dropped), 37'd0);
`endif
    wait_idle("backpressure");

    // ---- register zero: discarded entry delays the next write by one cycle ----
    @(negedge clock);
    bus.a_valid = 1'b1; bus.a_addr = 5'd0; bus.a_data = 32'hDEAD_BEEF;
    exp_q.push_back({5'd7, 32'h4000_0000});
    @(negedge clock);
    bus.a_addr = 5'd7; bus.a_data = 32'h4000_0000;
    @(negedge clock);
    idle_inputs();
    check("zero_no_wen", 37'(bus.wen), 37'd0);
    @(negedge clock);
    check("zero_next_wen", 37'(bus.wen), 37'd1);
    check("zero_next_wa",  37'(bus.wa),  37'd7);
    check("zero_next_wd",  37'(bus.wd),  37'h4000_0000);
    wait_idle("regzero");

    // ---- wrap-around: 10 sequential B entries while draining ----
    b_blocked = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      bus.b_valid = 1'b1;
      bus.b_addr  = 5'(i + 1);
      bus.b_data  = 32'hC000_0000 + 32'(i);
      exp_q.push_back({5'(i + 1), 32'hC000_0000 + 32'(i)});
      if (!bus.b_ready) b_blocked = 1'b1;
    end
    @(negedge clock);
    idle_inputs();
    check("wrap_b_never_full", 37'(b_blocked), 37'd0);
    wait_idle("wrap");

    // ---- asynchronous reset mid-stream ----
    @(negedge clock);
    bus.a_valid = 1'b1; bus.a_addr = 5'd17; bus.a_data = 32'h5555_0001;
    bus.b_valid = 1'b1; bus.b_addr = 5'd19; bus.b_data = 32'h6666_0001;
    @(negedge clock);
    bus.a_addr = 5'd18; bus.a_data = 32'h5555_0002;
    bus.b_addr = 5'd20; bus.b_data = 32'h6666_0002;
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check("midrst_wen",     37'(bus.wen),     37'd0);
    check("midrst_wa",      37'(bus.wa),      37'd0);
    check("midrst_wd",      37'(bus.wd),      37'd0);
    check("midrst_a_ready", 37'(bus.a_ready), 37'd1);
    check("midrst_b_ready", 37'(bus.b_ready), 37'd1);
    check("midrst_idle",    37'(bus.idle),    37'd1);
    idle_inputs();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    repeat (6) @(negedge clock);
    check("midrst_after_idle", 37'(bus.idle), 37'd1);
    check("midrst_after_wen",  37'(bus.wen),  37'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
